// File: rtl/ttt_game_ctrl_if.sv
// ttt_game_ctrl_if
// Bundles the keypad-side strobes and the display-side status of the
// tic-tac-toe game sequencer.
//   start, key_valid, key_code : keypad/control side -> sequencer
//   board, turn_o, result, state,
//   move_accept, move_reject, timeout : sequencer -> display side
// Modport "slave" is the sequencer's view; "master" is the surrounding system.
interface ttt_game_ctrl_if;
    logic        start;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result;
    logic [1:0]  state;
    logic        move_accept;
    logic        move_reject;
    logic        timeout;

    modport master (
        output start, key_valid, key_code,
        input  board, turn_o, result, state, move_accept, move_reject, timeout
    );

    modport slave (
        input  start, key_valid, key_code,
        output board, turn_o, result, state, move_accept, move_reject, timeout
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
// Tic-tac-toe game sequencer. Owns the board, validates one-cycle key
// strobes, alternates turns, detects win/draw one cycle after each accepted
// move, and optionally forfeits a turn after TURN_TIMEOUT idle cycles.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, returns every output to 0
//   bus  : ttt_game_ctrl_if.slave (start/key in; board/turn/result/state
//          and accept/reject/timeout pulses out, all registered)
// Parameter:
//   TURN_TIMEOUT : cycles allowed per turn, 0 disables (max 2^24-1)
module ttt_game_ctrl #(
    parameter int unsigned TURN_TIMEOUT = 32'd0
) (
    input  logic            clk,
    input  logic            rst,
    ttt_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic        TO_EN_C   = (TURN_TIMEOUT != 32'd0);
    localparam logic [23:0] TO_LAST_C = TO_EN_C ? 24'(TURN_TIMEOUT - 32'd1) : 24'd0;

    state_t      state_r;
    logic [17:0] board_r;
    logic        turn_r;
    logic [1:0]  result_r;
    logic        accept_r;
    logic        reject_r;
    logic        timeout_r;
    logic [23:0] tmr_r;

    logic [1:0]  mark_s;
    logic [1:0]  cell_sel_s;
    logic        key_hit_s;
    logic        key_ok_s;
    logic [17:0] board_wr_s;
    logic        expire_s;
    logic        win_s;
    logic        full_s;

    // Cell k (1..9) lives in bits [19-2k:18-2k], so cell 1 is the MSB pair.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input int k);
        cell_at = b[(9 - k) * 2 +: 2];
    endfunction

    // True when mark m owns any of the eight lines.
    function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
        logic [8:0] own;
        for (int k = 1; k <= 9; k++) begin
            own[k - 1] = (cell_at(b, k) == m);
        end
        has_line = (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
                   (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
                   (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
                   (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
    endfunction

    // True when no cell is empty.
    function automatic logic is_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            full = full & (cell_at(b, k) != 2'b00);
        end
        is_full = full;
    endfunction

    // Key decode, candidate board write and line/full evaluation.
    always_comb begin
        logic hit_k;
        mark_s     = turn_r ? 2'b10 : 2'b01;
        cell_sel_s = 2'b00;
        key_hit_s  = 1'b0;
        board_wr_s = board_r;
        for (int k = 1; k <= 9; k++) begin
            hit_k      = (bus.key_code == 4'(k));
            key_hit_s  = key_hit_s | hit_k;
            cell_sel_s = hit_k ? cell_at(board_r, k) : cell_sel_s;
            board_wr_s[(9 - k) * 2 +: 2] = hit_k ? mark_s : board_r[(9 - k) * 2 +: 2];
        end
        key_ok_s = bus.key_valid & key_hit_s & (cell_sel_s == 2'b00);
        expire_s = TO_EN_C & (tmr_r == TO_LAST_C);
        // In CHECK the turn has not toggled yet, so mark_s is the mover.
        win_s    = has_line(board_r, mark_s);
        full_s   = is_full(board_r);
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            board_r   <= 18'd0;
            turn_r    <= 1'b0;
            result_r  <= 2'b00;
            accept_r  <= 1'b0;
            reject_r  <= 1'b0;
            timeout_r <= 1'b0;
            tmr_r     <= 24'd0;
        end else begin
            accept_r  <= 1'b0;
            reject_r  <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        board_r  <= 18'd0;
                        result_r <= 2'b00;
                        turn_r   <= 1'b0;
                        tmr_r    <= 24'd0;
                        state_r  <= ST_PLAY;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                ST_PLAY: begin
                    if (key_ok_s) begin
                        // An accepted key beats a same-cycle expiry.
                        board_r  <= board_wr_s;
                        accept_r <= 1'b1;
                        state_r  <= ST_CHECK;
                    end else begin
                        reject_r <= bus.key_valid;
                        if (expire_s) begin
                            timeout_r <= 1'b1;
                            turn_r    <= ~turn_r;
                            tmr_r     <= 24'd0;
                        end else begin
                            tmr_r     <= TO_EN_C ? (tmr_r + 24'd1) : 24'd0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (win_s) begin
                        result_r <= mark_s;
                        state_r  <= ST_DONE;
                    end else if (full_s) begin
                        result_r <= 2'b11;
                        state_r  <= ST_DONE;
                    end else begin
                        turn_r   <= ~turn_r;
                        tmr_r    <= 24'd0;
                        state_r  <= ST_PLAY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.board       = board_r;
    assign bus.turn_o      = turn_r;
    assign bus.result      = result_r;
    assign bus.state       = state_r;
    assign bus.move_accept = accept_r;
    assign bus.move_reject = reject_r;
    assign bus.timeout     = timeout_r;

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game sequencer for the tic-tac-toe design. It sits between the keypad scanner and the display drivers (dot matrix and 7-segment). It accepts one-cycle key strobes, validates each move against the board it owns, alternates turns, checks for a win or draw, and enforces an optional per-turn timeout. The display side reads `board`, `turn_o`, `result` and `state` directly.

## Interface
- `TURN_TIMEOUT`, default 0: clk cycles allowed per turn. 0 disables the timeout. Maximum value is 2^24-1.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high; clock `clk`
- `start`  in  1  one-cycle pulse that begins a new game
- `key_valid`  in  1  one-cycle strobe: `key_code` is valid this cycle
- `key_code`  in  4  cell number 1..9; any other value is invalid
- `board`  out  18  cell k occupies bits [19-2k:18-2k]; 00 = empty, 01 = X, 10 = O
- `turn_o`  out  1  0 = X to move, 1 = O to move
- `result`  out  2  00 = in play, 01 = X wins, 10 = O wins, 11 = draw
- `state`  out  2  00 = IDLE, 01 = PLAY, 10 = CHECK, 11 = DONE
- `move_accept`  out  1  one-cycle pulse: a move was written
- `move_reject`  out  1  one-cycle pulse: a move was refused
- `timeout`  out  1  one-cycle pulse: the turn was forfeited

## Operation
- All outputs are registered. Reset values: all outputs 0 (state = IDLE, empty board, X to move).
- IDLE
  - `start` → clear `board`, `result` and `turn_o`, and go to PLAY.
  - `key_valid` is ignored.
- PLAY
  - `key_valid` with a code of 1..9 and an empty cell: write 01 (X, `turn_o`=0) or 10 (O, `turn_o`=1) into that cell, pulse `move_accept`, and go to CHECK.
  - `key_valid` with a code of 0 or 10..15, or with an occupied cell: pulse `move_reject`. Board, turn and state are unchanged.
  - `start` is ignored.
- CHECK (always exactly one cycle)
  - Evaluate the 8 lines (rows 123/456/789, columns 147/258/369, diagonals 159/357) for the player who just moved, using the updated board.
  - Win: `result` = 01 (X) or 10 (O), go to DONE.
  - Otherwise, board full: `result` = 11, go to DONE.
  - Otherwise: toggle `turn_o` and return to PLAY.
  - A win takes priority over draw when the 9th move completes a line.
  - `key_valid` and `start` are ignored; the key produces neither pulse.
- DONE
  - `board` and `result` hold.
  - `start` → clear the board, set `turn_o`=0 and `result`=00, and go to PLAY directly.
  - `key_valid` is ignored.
- Timeout (`TURN_TIMEOUT`≠0)
  - A 24-bit counter clears on every entry to PLAY and increments on each PLAY cycle.
  - When it reaches `TURN_TIMEOUT`-1 with no accepted key that cycle: pulse `timeout`, toggle `turn_o`, and clear the counter. The state stays PLAY and the board is unchanged.
  - An accepted key in the same cycle as expiry wins: the move is taken and there is no timeout.
  - A rejected key does not clear the counter.
- Reset asserted in any state returns every output to its reset value immediately; no partial game survives.

## Timing
- Key accept:
  - `key_valid` sampled at edge T in PLAY.
  - `board`, `move_accept` and `state`=CHECK are visible after T.
  - `result` and `turn_o` (or DONE) are visible after T+1.
  - Next key accepted at T+2 at the earliest.
- Key reject: `move_reject` high during the cycle after T.
- `start` at edge T (from IDLE or DONE): `state`=PLAY after T.
- `timeout` fires `TURN_TIMEOUT` cycles after PLAY entry when no move is made.
- Win/draw detection latency is 1 cycle after `move_accept`.

## Test plan
- Reset, `start`, keys 1,4,2,5,3 spaced 4 cycles apart → 5 `move_accept` pulses; `result`=01 and `state`=11 one cycle after the 5th accept; `board`=18'b01_01_01_10_10_00_00_00_00.
- Keys 5,5 → second key pulses `move_reject`; `turn_o` stays 1 and `board` is unchanged. Key 0 or 12 → `move_reject`.
- Draw: keys 1,2,3,5,4,6,8,7,9 → `result`=11. Win on last move: keys 1,2,3,5,8,6,4,9,7 → `result`=01, not 11.
- `TURN_TIMEOUT`=16, `start`, no keys → `timeout` pulses at cycles 16 and 32 after PLAY entry; `turn_o` goes 1 then 0. Key accepted on the expiry cycle → `move_accept` with no `timeout`.
- Key during CHECK or DONE → no pulses, no change. `start` in DONE → empty board, `turn_o`=0, `result`=00, PLAY.
- `rst` asserted mid-game (after 3 moves) between clock edges → all outputs 0 without waiting for a clock edge; `start` afterwards begins a clean game.
